// File: rtl/piece_drop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piece_drop_ctrl_pkg
// Description : Shared widths, default playfield geometry, lifecycle state
//               encodings and a small helper for the piece drop controller.
// Revision    : 1.0  initial release
// ============================================================================
package piece_drop_ctrl_pkg;

    // Pixel coordinate width for ref_x / ref_y
    localparam int unsigned c_POS_W = 10;

    // Lifecycle state encodings
    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE       = 3'd0;
    localparam state_t c_ST_SPAWN      = 3'd1;
    localparam state_t c_ST_FALL       = 3'd2;
    localparam state_t c_ST_LOCK_DELAY = 3'd3;
    localparam state_t c_ST_LOCKED     = 3'd4;

    // Larger of two unsigned values, used to size the shared tick counters
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_drop_ctrl_gravity_timer.sv
`default_nettype none
// ============================================================================
// Module      : gravity_timer
// Description : Counts frame ticks and emits a one-cycle step pulse on the
//               tick that brings the count up to the threshold, then restarts.
//               The threshold may change mid-count; the running count is
//               simply compared against the new value.
// Revision    : 1.0  initial release
// ============================================================================
module gravity_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_tick,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_threshold,
    output logic             o_step
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_reached;

    // Count value after this tick and whether it meets the threshold
    always_comb begin
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_reached = (w_cnt_inc >= i_threshold);
        o_step    = i_frame_tick & ~i_clear & w_reached;
    end

    // Tick counter: held at zero while cleared, wraps to zero on each step
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_frame_tick) begin
            r_cnt <= w_reached ? '0 : w_cnt_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piece_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piece_drop_ctrl
// Description : Owns the falling piece reference position and its lifecycle
//               (spawn, fall, lock delay, lock). Gravity and lock delay are
//               timed in frame ticks; sideways moves and lock-now come from
//               rising edges of debounced buttons.
// Revision    : 1.0  initial release
// ============================================================================
module piece_drop_ctrl
    import piece_drop_ctrl_pkg::*;
#(
    parameter int unsigned SIZE          = 16,
    parameter int unsigned FLOOR_Y       = 480,
    parameter int unsigned SPAWN_X       = 304,
    parameter int unsigned SPAWN_Y       = 0,
    parameter int unsigned X_MIN         = 0,
    parameter int unsigned X_MAX         = 560,
    parameter int unsigned GRAVITY_TICKS = 30,
    parameter int unsigned SOFT_TICKS    = 3,
    parameter int unsigned LOCK_TICKS    = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               left_block,
    input  logic               right_block,
    input  logic               stop,
    output logic [c_POS_W-1:0] ref_x,
    output logic [c_POS_W-1:0] ref_y,
    output logic               piece_active,
    output logic               lock,
    output logic               spawn_req
);

    localparam int unsigned c_CNT_W = $clog2(max_u(GRAVITY_TICKS, LOCK_TICKS) + 1);

    localparam logic [c_POS_W-1:0] c_SIZE        = c_POS_W'(SIZE);
    localparam logic [c_POS_W-1:0] c_SPAWN_X     = c_POS_W'(SPAWN_X);
    localparam logic [c_POS_W-1:0] c_SPAWN_Y     = c_POS_W'(SPAWN_Y);
    localparam logic [c_POS_W-1:0] c_X_MIN       = c_POS_W'(X_MIN);
    localparam logic [c_POS_W-1:0] c_X_MAX       = c_POS_W'(X_MAX);
    localparam logic [c_POS_W-1:0] c_LAST_ROW_Y  = c_POS_W'(FLOOR_Y - SIZE);

    localparam logic [c_CNT_W-1:0] c_GRAV_THR    = c_CNT_W'(GRAVITY_TICKS);
    localparam logic [c_CNT_W-1:0] c_SOFT_THR    = c_CNT_W'(SOFT_TICKS);
    localparam logic [c_CNT_W-1:0] c_LOCK_THR    = c_CNT_W'(LOCK_TICKS);

    state_t               r_state;
    state_t               w_state_next;

    logic [c_POS_W-1:0]   r_ref_x;
    logic [c_POS_W-1:0]   r_ref_y;

    logic                 r_left_d;
    logic                 r_right_d;
    logic                 r_down_d;

    logic                 w_left_edge;
    logic                 w_right_edge;
    logic                 w_down_edge;
    logic                 w_active;
    logic                 w_floor_hit;
    logic                 w_move_left;
    logic                 w_move_right;
    logic [c_CNT_W-1:0]   w_grav_thr;
    logic                 w_grav_clear;
    logic                 w_lock_clear;
    logic                 w_grav_step;
    logic                 w_lock_step;

    // Button edges, floor detection and legality of sideways moves
    always_comb begin
        w_left_edge  = btn_left  & ~r_left_d;
        w_right_edge = btn_right & ~r_right_d;
        w_down_edge  = btn_down  & ~r_down_d;
        w_active     = (r_state == c_ST_FALL) || (r_state == c_ST_LOCK_DELAY);
        // The last-row guard catches an empty shape whose stop never fires
        w_floor_hit  = stop || (r_ref_y == c_LAST_ROW_Y);
        // Opposing edges in the same cycle cancel out
        w_move_left  = w_active && w_left_edge && !w_right_edge &&
                       !left_block && (r_ref_x > c_X_MIN);
        w_move_right = w_active && w_right_edge && !w_left_edge &&
                       !right_block && (r_ref_x < c_X_MAX);
        w_grav_thr   = btn_down ? c_SOFT_THR : c_GRAV_THR;
        // Each timer restarts from zero whenever its state is (re)entered
        w_grav_clear = (r_state != c_ST_FALL);
        w_lock_clear = (r_state != c_ST_LOCK_DELAY);
    end

    gravity_timer #(
        .CNT_W        (c_CNT_W)
    ) u_grav_timer (
        .clk          (clk),
        .rst          (reset),
        .i_frame_tick (frame_tick),
        .i_clear      (w_grav_clear),
        .i_threshold  (w_grav_thr),
        .o_step       (w_grav_step)
    );

    gravity_timer #(
        .CNT_W        (c_CNT_W)
    ) u_lock_timer (
        .clk          (clk),
        .rst          (reset),
        .i_frame_tick (frame_tick),
        .i_clear      (w_lock_clear),
        .i_threshold  (c_LOCK_THR),
        .o_step       (w_lock_step)
    );

    // Delayed button copies for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left_d  <= 1'b0;
            r_right_d <= 1'b0;
            r_down_d  <= 1'b0;
        end else begin
            r_left_d  <= btn_left;
            r_right_d <= btn_right;
            r_down_d  <= btn_down;
        end
    end

    // Lifecycle state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lifecycle next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_SPAWN;
                end
            end
            c_ST_SPAWN: begin
                w_state_next = c_ST_FALL;
            end
            c_ST_FALL: begin
                if (w_grav_step && w_floor_hit) begin
                    w_state_next = c_ST_LOCK_DELAY;
                end
            end
            c_ST_LOCK_DELAY: begin
                // Losing support wins over any pending lock request
                if (!w_floor_hit) begin
                    w_state_next = c_ST_FALL;
                end else if (w_lock_step || w_down_edge) begin
                    w_state_next = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                w_state_next = c_ST_SPAWN;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Lifecycle outputs decoded from the current state
    always_comb begin
        piece_active = w_active;
        lock         = (r_state == c_ST_LOCKED);
        spawn_req    = (r_state == c_ST_SPAWN);
    end

    // Reference position: spawn load, sideways moves and gravity steps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_x <= c_SPAWN_X;
            r_ref_y <= c_SPAWN_Y;
        end else if (r_state == c_ST_SPAWN) begin
            r_ref_x <= c_SPAWN_X;
            r_ref_y <= c_SPAWN_Y;
        end else begin
            if (w_move_left) begin
                r_ref_x <= r_ref_x - c_SIZE;
            end else if (w_move_right) begin
                r_ref_x <= r_ref_x + c_SIZE;
            end
            if ((r_state == c_ST_FALL) && w_grav_step && !w_floor_hit) begin
                r_ref_y <= r_ref_y + c_SIZE;
            end
        end
    end

    assign ref_x = r_ref_x;
    assign ref_y = r_ref_y;

endmodule
`default_nettype wire

// File: tb/tb_piece_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_drop_ctrl
// Description : Self-checking bench for piece_drop_ctrl: a vector table,
//               hand-written lifecycle sequences and a randomized run
//               compared against a behavioural model of the piece.
// Revision    : 1.0  initial release
// ============================================================================
module tb_piece_drop_ctrl;

    localparam int c_SPAWN_X = 304;
    localparam int c_STEP    = 16;
    localparam int c_LAST_Y  = 464;
    localparam int c_XMAX    = 560;
    localparam int c_NV      = 20;
    localparam int c_NRAND   = 4000;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start, btn_left, btn_right, btn_down;
    logic       left_block, right_block, stop;
    logic [9:0] ref_x, ref_y;
    logic       piece_active, lock, spawn_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piece_drop_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_down     (btn_down),
        .left_block   (left_block),
        .right_block  (right_block),
        .stop         (stop),
        .ref_x        (ref_x),
        .ref_y        (ref_y),
        .piece_active (piece_active),
        .lock         (lock),
        .spawn_req    (spawn_req)
    );

    // in = {reset, start, frame_tick, left, right, down, stop}
    // eo = {piece_active, lock, spawn_req}
    typedef struct packed {
        logic [6:0] in;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [2:0] eo;
    } vec_t;

    vec_t vecs [c_NV];

    function automatic vec_t mk(input logic [6:0] in, input logic [9:0] ex,
                                input logic [9:0] ey, input logic [2:0] eo);
        vec_t v;
        v.in = in; v.ex = ex; v.ey = ey; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
        left_block = 1'b0; right_block = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Reset, start, and leave the piece in its first FALL cycle
    task automatic start_piece();
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    task automatic press_left();
        btn_left = 1'b1; cyc(); btn_left = 1'b0; cyc();
    endtask

    task automatic press_right();
        btn_right = 1'b1; cyc(); btn_right = 1'b0; cyc();
    endtask

    // ---------------- behavioural model of the piece ----------------
    typedef enum int { MD_IDLE, MD_SPAWN, MD_FALL, MD_REST, MD_LOCKED } mode_t;
    mode_t m_mode;
    int    m_x, m_y, m_fall_ticks, m_rest_ticks;
    bit    m_pl, m_pr, m_pd;

    // Advance the model by one clock using the inputs currently driven
    task automatic model_apply();
        bit le, re, de, grounded;
        int need;
        if (reset) begin
            m_mode = MD_IDLE; m_x = c_SPAWN_X; m_y = 0;
            m_fall_ticks = 0; m_rest_ticks = 0;
            m_pl = 0; m_pr = 0; m_pd = 0;
            return;
        end
        le = btn_left && !m_pl;
        re = btn_right && !m_pr;
        de = btn_down && !m_pd;
        m_pl = btn_left; m_pr = btn_right; m_pd = btn_down;
        grounded = stop || (m_y == c_LAST_Y);
        if (m_mode == MD_FALL || m_mode == MD_REST) begin
            if (le && !re && !left_block && m_x > 0)          m_x -= c_STEP;
            if (re && !le && !right_block && m_x < c_XMAX)    m_x += c_STEP;
        end
        case (m_mode)
            MD_IDLE:   if (start) m_mode = MD_SPAWN;
            MD_SPAWN:  begin m_mode = MD_FALL; m_fall_ticks = 0; m_x = c_SPAWN_X; m_y = 0; end
            MD_FALL: begin
                if (frame_tick) begin
                    need = btn_down ? 3 : 30;
                    m_fall_ticks++;
                    if (m_fall_ticks >= need) begin
                        m_fall_ticks = 0;
                        if (grounded) begin m_mode = MD_REST; m_rest_ticks = 0; end
                        else m_y += c_STEP;
                    end
                end
            end
            MD_REST: begin
                if (frame_tick) m_rest_ticks++;
                if (!grounded) begin m_mode = MD_FALL; m_fall_ticks = 0; end
                else if (m_rest_ticks >= 15 || de) m_mode = MD_LOCKED;
            end
            default:   m_mode = MD_SPAWN;
        endcase
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);

        // ---------------- vector table ----------------
        vecs[0]  = mk(7'b1000000, 10'd304, 10'd0,  3'b000);
        vecs[1]  = mk(7'b0000000, 10'd304, 10'd0,  3'b000);
        vecs[2]  = mk(7'b0100000, 10'd304, 10'd0,  3'b001);
        vecs[3]  = mk(7'b0000000, 10'd304, 10'd0,  3'b100);
        vecs[4]  = mk(7'b0001000, 10'd288, 10'd0,  3'b100);
        vecs[5]  = mk(7'b0000100, 10'd304, 10'd0,  3'b100);
        vecs[6]  = mk(7'b0010110, 10'd304, 10'd0,  3'b100);
        vecs[7]  = mk(7'b0010110, 10'd304, 10'd0,  3'b100);
        vecs[8]  = mk(7'b0010110, 10'd304, 10'd16, 3'b100);
        vecs[9]  = mk(7'b0001010, 10'd288, 10'd16, 3'b100);
        vecs[10] = mk(7'b0001110, 10'd304, 10'd16, 3'b100);
        vecs[11] = mk(7'b0000010, 10'd304, 10'd16, 3'b100);
        vecs[12] = mk(7'b0001110, 10'd304, 10'd16, 3'b100);
        vecs[13] = mk(7'b0010011, 10'd304, 10'd16, 3'b100);
        vecs[14] = mk(7'b0010011, 10'd304, 10'd16, 3'b100);
        vecs[15] = mk(7'b0010011, 10'd304, 10'd16, 3'b100);
        vecs[16] = mk(7'b0000001, 10'd304, 10'd16, 3'b100);
        vecs[17] = mk(7'b0000011, 10'd304, 10'd16, 3'b010);
        vecs[18] = mk(7'b0000000, 10'd304, 10'd16, 3'b001);
        vecs[19] = mk(7'b0000000, 10'd304, 10'd0,  3'b100);

        for (int i = 0; i < c_NV; i++) begin
            {reset, start, frame_tick, btn_left, btn_right, btn_down, stop} = vecs[i].in;
            cyc();
            chk($sformatf("vec%0d_x", i), ref_x, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), ref_y, vecs[i].ey);
            chk($sformatf("vec%0d_flags", i), {piece_active, lock, spawn_req}, vecs[i].eo);
        end

        // ---------------- normal gravity: 30 ticks per row ----------------
        do_reset();
        chk("rst_x", ref_x, 304);
        chk("rst_flags", {piece_active, lock, spawn_req}, 3'b000);
        start = 1'b1;
        cyc();
        chk("spawn_pulse", spawn_req, 1);
        start = 1'b0;
        cyc();
        chk("fall_active", {piece_active, spawn_req}, 2'b10);
        chk("fall_x", ref_x, 304);
        ticks(29);
        chk("grav_29_y", ref_y, 0);
        ticks(1);
        chk("grav_30_y", ref_y, 16);

        // ---------------- floor guard and lock timing ----------------
        start_piece();
        btn_down = 1'b1;
        ticks(87);
        chk("floor_reach_y", ref_y, 464);
        ticks(3);
        chk("floor_rest_y", ref_y, 464);
        chk("floor_rest_act", {piece_active, lock}, 2'b10);
        ticks(14);
        chk("lock_14_flags", {piece_active, lock}, 2'b10);
        ticks(1);
        chk("lock_15_flags", {piece_active, lock}, 2'b01);
        chk("lock_hold_y", ref_y, 464);
        cyc();
        chk("respawn_req", spawn_req, 1);
        cyc();
        chk("respawn_x", ref_x, 304);
        chk("respawn_y", ref_y, 0);
        btn_down = 1'b0;

        // ---------------- sideways bounds and blocking ----------------
        start_piece();
        repeat (19) press_left();
        chk("left_to_min", ref_x, 0);
        press_left();
        chk("left_at_min", ref_x, 0);
        right_block = 1'b1;
        press_right();
        chk("right_blocked", ref_x, 0);
        right_block = 1'b0;
        repeat (35) press_right();
        chk("right_to_max", ref_x, 560);
        press_right();
        chk("right_at_max", ref_x, 560);
        left_block = 1'b1;
        press_left();
        chk("left_blocked", ref_x, 560);
        left_block = 1'b0;

        // ---------------- leave lock delay, then lock on down edge --------
        start_piece();
        stop = 1'b1;
        ticks(30);
        chk("ld_enter_y", ref_y, 0);
        chk("ld_enter_act", piece_active, 1);
        ticks(7);
        stop = 1'b0;
        cyc();
        chk("ld_exit_flags", {piece_active, lock}, 2'b10);
        ticks(29);
        chk("ld_refall_29_y", ref_y, 0);
        ticks(1);
        chk("ld_refall_30_y", ref_y, 16);
        stop = 1'b1;
        ticks(30);
        chk("ld_again_flags", {piece_active, lock}, 2'b10);
        btn_down = 1'b1;
        cyc();
        chk("down_edge_lock", lock, 1);
        btn_down = 1'b0;
        stop = 1'b0;

        // ---------------- reset mid-fall aborts the piece ----------------
        start_piece();
        btn_down = 1'b1;
        ticks(36);
        chk("mid_fall_y", ref_y, 192);
        reset = 1'b1;
        cyc();
        chk("abort_x", ref_x, 304);
        chk("abort_y", ref_y, 0);
        chk("abort_flags", {piece_active, lock, spawn_req}, 3'b000);
        reset = 1'b0;
        btn_down = 1'b0;
        cyc();
        chk("abort_idle", {piece_active, lock, spawn_req}, 3'b000);

        // ---------------- randomized run against the model ----------------
        clear_inputs();
        for (int i = 0; i < c_NRAND; i++) begin
            reset       = (i == 0) || ($urandom_range(0, 399) == 0);
            start       = ($urandom_range(0, 3) != 0);
            frame_tick  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 5) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 7) == 0) btn_down  = ~btn_down;
            left_block  = ($urandom_range(0, 3) == 0);
            right_block = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) stop = ~stop;
            model_apply();
            cyc();
            chk("rnd_x", ref_x, m_x);
            chk("rnd_y", ref_y, m_y);
            chk("rnd_active", piece_active, (m_mode == MD_FALL || m_mode == MD_REST));
            chk("rnd_lock", lock, (m_mode == MD_LOCKED));
            chk("rnd_spawn", spawn_req, (m_mode == MD_SPAWN));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
